// File: rtl/alu_operand_entry.sv
// Board-side operand entry for the ALU lab: debounces enter/clear buttons and
// steps num1 -> op -> send, handing both operands off over a valid/ready pair.
module alu_operand_entry #(
   parameter int DB_CYCLES = 20,
   parameter int CW        = $clog2(DB_CYCLES + 1)
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] sw,
   input  logic       btn_enter,
   input  logic       btn_clr,
   input  logic       out_ready,
   output logic [7:0] num1,
   output logic [2:0] op,
   output logic       out_valid,
   output logic [1:0] stage
);

   localparam int NB = 2;

   typedef enum logic [1:0] {
      S_NUM  = 2'b00,
      S_OP   = 2'b01,
      S_SEND = 2'b10
   } state_t;

   logic [NB-1:0] btn_raw;
   logic [NB-1:0] btn_ev;
   logic          enter_ev;
   logic          clr_ev;

   assign btn_raw  = {btn_clr, btn_enter};
   assign enter_ev = btn_ev[0];
   assign clr_ev   = btn_ev[1];

   // Per button: 2-flop synchroniser, stability counter, rising-edge event.
   generate
      for (genvar gi = 0; gi < NB; gi++) begin : gen_btn
         logic          sync1_reg;
         logic          sync2_reg;
         logic          db_reg;
         logic          ev_reg;
         logic [CW-1:0] cnt_reg;

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               sync1_reg <= 1'b0;
               sync2_reg <= 1'b0;
               db_reg    <= 1'b0;
               ev_reg    <= 1'b0;
               cnt_reg   <= '0;
            end else begin
               sync1_reg <= btn_raw[gi];
               sync2_reg <= sync1_reg;
               ev_reg    <= 1'b0;
               if (sync2_reg == db_reg) begin
                  cnt_reg <= '0;
               end else if (cnt_reg == CW'(DB_CYCLES - 1)) begin
                  // Level flips on the DB_CYCLES-th differing cycle; only a press is an event.
                  db_reg  <= ~db_reg;
                  cnt_reg <= '0;
                  ev_reg  <= ~db_reg;
               end else begin
                  cnt_reg <= cnt_reg + CW'(1);
               end
            end
         end

         assign btn_ev[gi] = ev_reg;
      end
   endgenerate

   state_t     state_reg, state_next;
   logic [7:0] num1_reg, num1_next;
   logic [2:0] op_reg, op_next;
   logic       valid_reg, valid_next;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= S_NUM;
         num1_reg  <= 8'd0;
         op_reg    <= 3'd0;
         valid_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         num1_reg  <= num1_next;
         op_reg    <= op_next;
         valid_reg <= valid_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      num1_next  = num1_reg;
      op_next    = op_reg;
      valid_next = valid_reg;
      if (clr_ev) begin
         // Clear overrides enter and any handshake in the same cycle.
         state_next = S_NUM;
         num1_next  = 8'd0;
         op_next    = 3'd0;
         valid_next = 1'b0;
      end else begin
         case (state_reg)
            S_NUM: begin
               if (enter_ev) begin
                  num1_next  = sw;
                  state_next = S_OP;
               end
            end
            S_OP: begin
               if (enter_ev) begin
                  op_next    = sw[2:0];
                  valid_next = 1'b1;
                  state_next = S_SEND;
               end
            end
            S_SEND: begin
               // Operands are frozen here; enter presses are dropped.
               if (valid_reg && out_ready) begin
                  valid_next = 1'b0;
                  state_next = S_NUM;
               end
            end
            default: begin
               state_next = S_NUM;
               valid_next = 1'b0;
            end
         endcase
      end
   end

   assign num1      = num1_reg;
   assign op        = op_reg;
   assign out_valid = valid_reg;
   assign stage     = state_reg;

endmodule

// File: tb/tb_alu_operand_entry.sv
// Scoreboard bench for alu_operand_entry: stimulus queues each expected output
// change, a negedge monitor pops and compares whenever the outputs move.
module tb_alu_operand_entry;

   localparam int DB = 4;

   logic       clk;
   logic       rst;
   logic [7:0] sw;
   logic       btn_enter;
   logic       btn_clr;
   logic       out_ready;
   logic [7:0] num1;
   logic [2:0] op;
   logic       out_valid;
   logic [1:0] stage;

   alu_operand_entry #(.DB_CYCLES(DB)) dut (
      .clk       (clk),
      .rst       (rst),
      .sw        (sw),
      .btn_enter (btn_enter),
      .btn_clr   (btn_clr),
      .out_ready (out_ready),
      .num1      (num1),
      .op        (op),
      .out_valid (out_valid),
      .stage     (stage)
   );

   typedef struct {
      logic [7:0] num1;
      logic [2:0] op;
      logic       valid;
      logic [1:0] stage;
      int         cyc;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required finish before 200000 ns");
      $fatal(1);
   end

   // Monitor: any output change while out of reset must match the queue head.
   logic [13:0] mon_prev;
   bit          mon_ok = 1'b0;
   always @(negedge clk) begin
      logic [13:0] cur;
      exp_t        e;
      cur = {num1, op, out_valid, stage};
      if (rst && mon_ok && cur != mon_prev) begin
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_change: got num1=%h op=%0d valid=%0b stage=%b at cyc %0d, required no change",
                     num1, op, out_valid, stage, cyc);
         end else begin
            e = sb_q.pop_front();
            if (num1 !== e.num1 || op !== e.op || out_valid !== e.valid || stage !== e.stage ||
                (e.cyc >= 0 && e.cyc != cyc)) begin
               errors++;
               $display("FAIL txn: got num1=%h op=%0d valid=%0b stage=%b cyc=%0d, required num1=%h op=%0d valid=%0b stage=%b cyc=%0d",
                        num1, op, out_valid, stage, cyc, e.num1, e.op, e.valid, e.stage, e.cyc);
            end else begin
               $display("ok txn: num1=%h op=%0d valid=%0b stage=%b cyc=%0d", num1, op, out_valid, stage, cyc);
            end
         end
      end
      mon_prev = cur;
      mon_ok   = rst;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input logic [7:0] n1, input logic [2:0] o, input logic v,
                             input logic [1:0] st, input int c);
      exp_t e;
      e.num1 = n1; e.op = o; e.valid = v; e.stage = st; e.cyc = c;
      sb_q.push_back(e);
   endtask

   task automatic press(input logic en, input logic cl, input int n);
      btn_enter = en;
      btn_clr   = cl;
      tick(n);
      btn_enter = 1'b0;
      btn_clr   = 1'b0;
      tick(DB + 8);
   endtask

   task automatic drain(input string name);
      int waited = 0;
      while (sb_q.size() != 0 && waited < 200) begin
         tick(1);
         waited++;
      end
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL drain_%s: %0d expected changes never seen, required 0", name, sb_q.size());
         sb_q.delete();
      end else begin
         $display("ok drain_%s", name);
      end
   endtask

   task automatic check_now(input string name, input logic [13:0] got, input logic [13:0] req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, got, req);
      end else begin
         $display("ok %s: %h", name, got);
      end
   endtask

   initial begin
      rst = 1'b0; sw = 8'h00; btn_enter = 1'b0; btn_clr = 1'b0; out_ready = 1'b0;

      // 1: reset
      tick(3);
      check_now("reset_low", {num1, op, out_valid, stage}, 14'h0);
      rst = 1'b1;
      tick(3);
      check_now("reset_release", {num1, op, out_valid, stage}, 14'h0);

      // 2: full entry, ready with no valid is ignored, hold then handshake
      out_ready = 1'b1;
      tick(5);
      out_ready = 1'b0;
      sw = 8'h02;
      expect_out(8'h02, 3'd0, 1'b0, 2'b01, -1);
      press(1'b1, 1'b0, 10);
      sw = 8'h01;
      expect_out(8'h02, 3'd1, 1'b1, 2'b10, -1);
      press(1'b1, 1'b0, 10);
      drain("entry");
      sw = 8'hFF;
      tick(20);
      check_now("held_send", {num1, op, out_valid, stage}, {8'h02, 3'd1, 1'b1, 2'b10});
      expect_out(8'h02, 3'd1, 1'b0, 2'b00, -1);
      out_ready = 1'b1;
      tick(1);
      out_ready = 1'b0;
      drain("handshake");

      // 3: bounce and short pulses give nothing; 4-cycle pulse gives one event
      sw = 8'h3C;
      for (int i = 0; i < 4; i++) begin
         btn_enter = ~btn_enter;
         tick(1);
      end
      btn_enter = 1'b0;
      tick(12);
      press(1'b1, 1'b0, 3);
      check_now("short_pulse", {num1, op, out_valid, stage}, {8'h02, 3'd1, 1'b0, 2'b00});
      expect_out(8'h3C, 3'd1, 1'b0, 2'b01, -1);
      press(1'b1, 1'b0, 4);
      drain("pulse4");
      expect_out(8'h00, 3'd0, 1'b0, 2'b00, -1);
      press(1'b0, 1'b1, 10);
      drain("clr_op");

      // 4: latency from raw rise, long hold is one event
      sw = 8'h77;
      btn_enter = 1'b1;
      expect_out(8'h77, 3'd0, 1'b0, 2'b01, cyc + 7);
      tick(100);
      btn_enter = 1'b0;
      tick(DB + 8);
      drain("latency");

      // 6: reset in S_OP while enter bounces, then held enter across release
      btn_enter = 1'b1; tick(1);
      btn_enter = 1'b0; tick(1);
      btn_enter = 1'b1; tick(1);
      #2 rst = 1'b0;
      #1;
      check_now("async_reset", {num1, op, out_valid, stage}, 14'h0);
      sw = 8'h5A;
      tick(3);
      rst = 1'b1;
      expect_out(8'h5A, 3'd0, 1'b0, 2'b01, cyc + 7);
      tick(30);
      btn_enter = 1'b0;
      tick(DB + 8);
      drain("reset_hold");

      // 5: clear and enter together in S_SEND
      expect_out(8'h00, 3'd0, 1'b0, 2'b00, -1);
      press(1'b0, 1'b1, 10);
      sw = 8'hA5;
      expect_out(8'hA5, 3'd0, 1'b0, 2'b01, -1);
      press(1'b1, 1'b0, 10);
      sw = 8'h06;
      expect_out(8'hA5, 3'd6, 1'b1, 2'b10, -1);
      press(1'b1, 1'b0, 10);
      drain("send_a5");
      expect_out(8'h00, 3'd0, 1'b0, 2'b00, -1);
      press(1'b1, 1'b1, 10);
      tick(30);
      drain("clr_enter");
      check_now("after_clr", {num1, op, out_valid, stage}, 14'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
